// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder and its RAM bank.
package dmem_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   localparam int DW_BYTES       = 8;
   localparam int DW_BITS        = 64;
   localparam int CNT_W          = 4;
   localparam int DEPTH_LOG2_DEF = 10;
   localparam int IDX_W_DEF      = DEPTH_LOG2_DEF;

   // Start value of the latency down-counter for a given request-to-response latency.
   function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Synchronous single-port doubleword RAM with per-byte write enables; read data registers
// on the access edge and shows the contents from before any write on that same edge.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [DW_BYTES-1:0]   be,
   input  logic [DW_BITS-1:0]    wdata,
   output logic [DW_BITS-1:0]    rdata
);

   logic [DW_BITS-1:0] mem_q [2**DEPTH_LOG2];
   logic [DW_BITS-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DW_BYTES; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed-latency response, byte-masked stores.
// Optional out-of-range error reporting is enabled by defining DMEM_ERR_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// WAIT    | request latched, latency counter running down
// RESP    | response presented, held until rsp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int LATENCY    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [63:0]         req_addr,
   input  logic [DW_BITS-1:0]  req_wdata,
   input  logic [DW_BYTES-1:0] req_wmask,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DW_BITS-1:0]  rsp_rdata,
   output logic                rsp_err
);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wen_q, wen_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [DW_BITS-1:0]    wdata_q, wdata_d;
   logic [DW_BYTES-1:0]   wmask_q, wmask_d;
   logic                  err_q, err_d;
   logic                  addr_oor;
   logic                  commit;
   logic [DW_BYTES-1:0]   bank_be;
   logic [DW_BITS-1:0]    bank_rdata;

`ifdef DMEM_ERR_EN
   logic unused_addr;
   assign unused_addr = ^req_addr[2:0];
   assign addr_oor    = |req_addr[63:DEPTH_LOG2+3];
   assign rsp_err     = rsp_valid && err_q;
`else
   logic unused_addr;
   assign unused_addr = ^{req_addr[63:DEPTH_LOG2+3], req_addr[2:0]};
   assign addr_oor    = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = (rsp_valid && !wen_q && !err_q) ? bank_rdata : '0;

   // The access fires on the last WAIT edge; a reset on that edge wins so nothing is written.
   assign commit  = (state_q == ST_WAIT) && (cnt_q == '0) && !rst;
   assign bank_be = (wen_q && !err_q) ? wmask_q : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               idx_d   = req_addr[DEPTH_LOG2+2:3];
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               err_d   = addr_oor;
               cnt_d   = lat_to_cnt(LATENCY);
               // LATENCY=1 still passes through one WAIT cycle (cnt=0) so the registered
               // RAM read lands exactly one cycle after accept.
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         err_q   <= err_d;
      end
   end

   dmem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
      .clk   (clk),
      .en    (commit),
      .idx   (idx_q),
      .be    (bank_be),
      .wdata (wdata_q),
      .rdata (bank_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver pushes model-predicted responses at accept,
// a negedge monitor pops and compares them and checks latency and hold-under-backpressure.
module tb_dmem_responder;

   localparam int DEPTH_LOG2 = 10;
   localparam int LAT        = 4;
   localparam int N_INIT     = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] mem_m[int];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       rsp_ready = ($urandom_range(0, 3) != 0);
         1:       rsp_ready = 1'b0;
         default: rsp_ready = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Monitor: compares every handshaken response against the front of the scoreboard.
   logic        pend = 1'b0;
   logic [63:0] held_rdata;
   logic        held_err;

   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else if (rsp_valid) begin
         if (!pend) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
               chk("latency", 64'(cyc - exp_q[0].acc), 64'(LAT));
            end
            held_rdata = rsp_rdata;
            held_err   = rsp_err;
         end else begin
            chk("hold_rdata", rsp_rdata, held_rdata);
            chk("hold_err", 64'(rsp_err), 64'(held_err));
            chk("resp_req_ready", 64'(req_ready), 64'd0);
         end
         if (rsp_ready && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
         pend = !rsp_ready;
      end else begin
         pend = 1'b0;
      end
   end

   // Driver: waits for acceptance, applies the request to the reference model, pushes expectation.
   task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask);
      exp_t        e;
      int          guard;
      int          idx;
      logic        oor;
      logic [63:0] word;
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      guard = 0;
      while (!req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         timeout("accept");
         req_valid = 1'b0;
         return;
      end
      idx = int'(addr[DEPTH_LOG2+2:3]);
      oor = 1'b0;
`ifdef DMEM_ERR_EN
      oor = |addr[63:DEPTH_LOG2+3];
`endif
      e.err = oor;
      e.acc = cyc + 1;
      if (wen) begin
         e.rdata = '0;
         if (!oor) begin
            word = mem_m[idx];
            for (int i = 0; i < 8; i++)
               if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
            mem_m[idx] = word;
         end
      end else begin
         e.rdata = oor ? 64'd0 : mem_m[idx];
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wen   = 1'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || rsp_valid) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         timeout("drain");
         exp_q.delete();
      end
   endtask

   initial begin
      int guard;
      logic [63:0] a;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);

      for (int i = 0; i < N_INIT; i++)
         issue(1'b1, 64'(i) << 3, {$urandom, $urandom}, 8'hFF);

      // Full store then load.
      issue(1'b1, 64'h40, 64'h1122334455667788, 8'hFF);
      issue(1'b0, 64'h40, 64'h0, 8'h00);

      // Partial mask and zero-mask no-op store.
      issue(1'b1, 64'h80, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      issue(1'b1, 64'h80, 64'h0, 8'h0F);
      issue(1'b1, 64'h80, 64'h5555555555555555, 8'h00);
      issue(1'b0, 64'h85, 64'h0, 8'hFF);
      drain();

      // Backpressure with a stray request pulse that must be ignored.
      rdy_mode = 1;
      issue(1'b0, 64'h40, 64'h0, 8'h00);
      guard = 0;
      while (!rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!rsp_valid) timeout("bp_valid");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = (k == 2);
         req_wen   = 1'b1;
         req_addr  = 64'h28;
         req_wdata = 64'hDEADBEEFCAFEF00D;
         req_wmask = 8'hFF;
      end
      @(negedge clk);
      req_valid = 1'b0;
      rdy_mode  = 2;
      guard = 0;
      while (!(rsp_valid && rsp_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!(rsp_valid && rsp_ready)) timeout("bp_release");
      @(negedge clk);
      chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
      chk("bp_idle_ready", 64'(req_ready), 64'd1);
      issue(1'b0, 64'h28, 64'h0, 8'h00);
      drain();

      // Reset during the second WAIT cycle drops the store.
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 64'h100;
      req_wdata = 64'hFFFFFFFFFFFFFFFF;
      req_wmask = 8'hFF;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) timeout("rst_accept");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midop_rst_valid", 64'(rsp_valid), 64'd0);
      chk("midop_rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(1'b0, 64'h100, 64'h0, 8'h00);
      drain();

      // Out-of-range (or aliasing) accesses.
      issue(1'b0, 64'(1) << (DEPTH_LOG2 + 3), 64'h0, 8'h00);
      issue(1'b1, (64'(1) << 40) | 64'h8, 64'h0123456789ABCDEF, 8'hFF);
      issue(1'b0, 64'h8, 64'h0, 8'h00);
      drain();

      // Randomized traffic with random consumer backpressure.
      rdy_mode = 0;
      for (int n = 0; n < 150; n++) begin
         a = (64'($urandom_range(0, N_INIT - 1)) << 3) | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a[DEPTH_LOG2 + 3 + $urandom_range(0, 50)] = 1'b1;
         issue(1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rdy_mode = 2;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish (checks=%0d)", checks);
      $fatal(1);
   end

endmodule
